// File: rtl/hilo_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine that owns the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fix-up cycle.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   input  logic             hlwrite,
   input  logic             hlsel,
   input  logic [WIDTH-1:0] hlwdata,
   input  logic             mfhl_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic             stall
);

   localparam int CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } engineState;

   engineState         state;
   logic               divOp;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic               negResult;
   logic               negDividend;
   logic [CNTW-1:0]    counter;
   logic [2*WIDTH-1:0] acc;

   // Operand conditioning at accept: signed ops work on magnitudes.
   logic               signedIn;
   logic [WIDTH-1:0]   aMagIn;
   logic [WIDTH-1:0]   bMagIn;

   assign signedIn = ~op[0];
   assign aMagIn   = (signedIn && srca[WIDTH-1]) ? -srca : srca;
   assign bMagIn   = (signedIn && srcb[WIDTH-1]) ? -srcb : srcb;

   // Single iteration step. Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic               divFits;
   logic [WIDTH-1:0]   divRem;
   logic [2*WIDTH-1:0] accStep;

   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : {(WIDTH+1){1'b0}});
      divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divFits  = (divShift >= {1'b0, bMag});
      divRem   = divFits ? WIDTH'(divShift - {1'b0, bMag}) : divShift[WIDTH-1:0];
      if (divOp) begin
         accStep = {divRem, acc[WIDTH-2:0], divFits};
      end else begin
         accStep = {mulSum, acc[WIDTH-1:1]};
      end
   end

   // Sign fix-up and result mapping applied on the FIX edge.
   logic               divByZero;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic [WIDTH-1:0]   hiFix;
   logic [WIDTH-1:0]   loFix;

   always_comb begin
      divByZero = divOp && (bMag == '0);
      product   = negResult ? -acc : acc;
      quotient  = negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remainder = negDividend ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      hiFix     = product[2*WIDTH-1:WIDTH];
      loFix     = product[WIDTH-1:0];
      if (divOp) begin
         if (divByZero) begin
            // Divide by zero hands back the original dividend in HI.
            hiFix = negDividend ? -aMag : aMag;
            loFix = '1;
         end else begin
            hiFix = remainder;
            loFix = quotient;
         end
      end
   end

   assign stall = mfhl_req & busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div0        <= 1'b0;
         divOp       <= 1'b0;
         aMag        <= '0;
         bMag        <= '0;
         negResult   <= 1'b0;
         negDividend <= 1'b0;
         counter     <= '0;
         acc         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hlwrite) begin
                  if (hlsel) begin
                     hi <= hlwdata;
                  end else begin
                     lo <= hlwdata;
                  end
               end
               if (start && !flush) begin
                  divOp       <= op[1];
                  aMag        <= aMagIn;
                  bMag        <= bMagIn;
                  negResult   <= signedIn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                  negDividend <= signedIn & srca[WIDTH-1];
                  counter     <= CNTW'(WIDTH);
                  acc         <= {{WIDTH{1'b0}}, (op[1] ? aMagIn : bMagIn)};
                  div0        <= 1'b0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc     <= accStep;
                  counter <= counter - CNTW'(1);
                  if (counter == CNTW'(1)) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (!flush) begin
                  hi   <= hiFix;
                  lo   <= loFix;
                  div0 <= divByZero;
                  done <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized bench for hilo_muldiv_unit, checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] srca;
   logic [W-1:0] srcb;
   logic         flush;
   logic         hlwrite;
   logic         hlsel;
   logic [W-1:0] hlwdata;
   logic         mfhl_req;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div0;
   logic         stall;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] expHi;
   logic [W-1:0] expLo;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .flush(flush), .hlwrite(hlwrite), .hlsel(hlsel), .hlwdata(hlwdata),
      .mfhl_req(mfhl_req), .hi(hi), .lo(lo), .busy(busy), .done(done),
      .div0(div0), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {div0, hi, lo} straight from the arithmetic definition of each operation.
   function automatic logic [2*W:0] refModel(input logic [1:0] opCode, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (opCode)
         2'b00: begin
            p = 64'(sa * sb);
            return {1'b0, p};
         end
         2'b01: begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
         end
         default: begin
            if (b == '0) return {1'b1, a, {W{1'b1}}};
            if (opCode == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               return {1'b0, sr[W-1:0], sq[W-1:0]};
            end
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // One full operation; hlAt/startAt inject a write/start after that many post-accept edges (-1 = never).
   task automatic runOp(input logic [1:0] opCode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit holdReq, input int hlAt, input int startAt);
      logic [2*W:0] exp;
      int n, busyCnt, stallCnt, holdBad;
      exp = refModel(opCode, a, b);
      start = 1'b1; op = opCode; srca = a; srcb = b; mfhl_req = holdReq;
      tick();
      start = 1'b0; srca = $urandom; srcb = $urandom;
      check("div0_clear_on_accept", 64'(div0), 64'(0));
      n = 0; busyCnt = 0; stallCnt = 0; holdBad = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busyCnt++;
         if (stall === 1'b1) stallCnt++;
         if (hi !== expHi || lo !== expLo) holdBad++;
         hlwrite = (n == hlAt);
         hlsel   = 1'($urandom_range(0, 1));
         hlwdata = $urandom;
         if (n == startAt) begin
            start = 1'b1; op = 2'($urandom_range(0, 3)); srca = $urandom; srcb = $urandom;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      hlwrite = 1'b0;
      start   = 1'b0;
      check("latency", 64'(n), 64'(33));
      check("busy_cycles", 64'(busyCnt), 64'(33));
      check("stall_cycles", 64'(stallCnt), holdReq ? 64'(33) : 64'(0));
      check("hilo_hold_while_busy", 64'(holdBad), 64'(0));
      check("busy_in_done_cycle", 64'(busy), 64'(0));
      check("stall_in_done_cycle", 64'(stall), 64'(0));
      check("hi", 64'(hi), 64'(exp[2*W-1:W]));
      check("lo", 64'(lo), 64'(exp[W-1:0]));
      check("div0", 64'(div0), 64'(exp[2*W]));
      $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h div0=%0b", opCode, a, b, hi, lo, div0);
      expHi = exp[2*W-1:W];
      expLo = exp[W-1:0];
      mfhl_req = 1'b0;
      tick();
      check("done_single_pulse", 64'(done), 64'(0));
   endtask

   initial begin
      int doneSeen;
      logic [1:0]   rOp;
      logic [W-1:0] rA, rB, d;
      reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; flush = 1'b0;
      hlwrite = 1'b0; hlsel = 1'b0; hlwdata = '0; mfhl_req = 1'b0;
      #2 reset = 1'b0;
      tick();
      tick();
      check("reset_hi", 64'(hi), 64'(0));
      check("reset_lo", 64'(lo), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_div0", 64'(div0), 64'(0));
      reset = 1'b1;
      expHi = '0; expLo = '0;
      tick();

      runOp(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, -1, -1);
      runOp(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, -1, -1);
      runOp(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, -1, -1);
      runOp(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, -1, -1);
      runOp(2'b11, 32'd100, 32'd7, 1'b0, -1, -1);
      runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, -1);
      runOp(2'b11, 32'd5, 32'd0, 1'b0, -1, -1);
      runOp(2'b01, 32'd1, 32'd1, 1'b0, -1, -1);
      runOp(2'b10, 32'hFFFF0000, 32'd0, 1'b0, -1, -1);

      // Held read request, mid-operation write and start, write on the FIX edge.
      runOp(2'b10, 32'd123457, 32'hFFFFFFB3, 1'b1, 10, 15);
      runOp(2'b00, $urandom, $urandom, 1'b0, 32, -1);

      // Writes while idle take effect at the next edge.
      hlwrite = 1'b1; hlsel = 1'b0; hlwdata = 32'h0000ABCD;
      tick();
      hlwrite = 1'b0;
      check("idle_write_lo", 64'(lo), 64'h0000ABCD);
      check("idle_write_keeps_hi", 64'(hi), 64'(expHi));
      expLo = 32'h0000ABCD;
      d = $urandom;
      hlwrite = 1'b1; hlsel = 1'b1; hlwdata = d;
      tick();
      hlwrite = 1'b0;
      check("idle_write_hi", 64'(hi), 64'(d));
      check("idle_write_keeps_lo", 64'(lo), 64'(expLo));
      expHi = d;

      // Flush during a divide.
      start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd3;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_hi", 64'(hi), 64'(expHi));
      check("flush_lo", 64'(lo), 64'(expLo));
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) doneSeen++;
         tick();
      end
      check("flush_no_done", 64'(doneSeen), 64'(0));
      check("flush_hilo_after", {hi, lo}, {expHi, expLo});

      // Flush beats start when both arrive in IDLE.
      start = 1'b1; flush = 1'b1; op = 2'b01; srca = 32'd9; srcb = 32'd9;
      tick();
      start = 1'b0; flush = 1'b0;
      check("flush_start_idle_busy", 64'(busy), 64'(0));
      tick();
      check("flush_start_idle_busy2", 64'(busy), 64'(0));

      // Randomized operations with occasional corner operands.
      for (int k = 0; k < 16; k++) begin
         rOp = 2'($urandom_range(0, 3));
         rA  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rB = '0;
            1:       rB = 32'hFFFFFFFF;
            2:       rB = 32'($urandom_range(1, 20));
            default: rB = $urandom;
         endcase
         runOp(rOp, rA, rB, k[0], -1, -1);
      end

      // Asynchronous reset in the middle of a multiply.
      start = 1'b1; op = 2'b00; srca = 32'h12345678; srcb = 32'h9ABCDEF0; mfhl_req = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      check("busy_before_reset", 64'(busy), 64'(1));
      #2 reset = 1'b0;
      #1;
      check("areset_hi", 64'(hi), 64'(0));
      check("areset_lo", 64'(lo), 64'(0));
      check("areset_busy", 64'(busy), 64'(0));
      check("areset_done", 64'(done), 64'(0));
      check("areset_div0", 64'(div0), 64'(0));
      check("areset_stall", 64'(stall), 64'(0));
      mfhl_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("post_reset_idle", 64'(busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine with its own HI/LO register pair, for the execute stage of the pipelined MIPS datapath.
- Supersedes the single-cycle HI/LO write path, where the multiply/divide result is written through the pipeline via the HI/LO write enable.
- Provides signed and unsigned MULT/DIV with a start/busy/done handshake, MTHI/MTLO writes, and a stall request for HI/LO reads that hit a pending result.
- Supports flush of an in-flight operation.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO.
CNTW, $clog2(WIDTH+1), iteration-counter width (derived; not overridden).

Ports:
clk  in  1  sole clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
srca  in  WIDTH  multiplicand / dividend.
srcb  in  WIDTH  multiplier / divisor.
flush  in  1  abort in-flight operation (execute-stage flush).
hlwrite  in  1  MTHI/MTLO write strobe.
hlsel  in  1  0 writes LO, 1 writes HI.
hlwdata  in  WIDTH  MTHI/MTLO data.
mfhl_req  in  1  decode/execute wants to read HI or LO this cycle.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
div0  out  1  sticky; last DIV/DIVU had zero divisor; cleared by next accepted start.
stall  out  1  combinational: mfhl_req & busy.

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE; hi=0, lo=0, busy=0, done=0, div0=0; counter and working registers cleared. No partial result survives.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 latches op, |srca|, |srcb| (absolute values for signed ops) and the result sign bits; loads counter=WIDTH; goes to RUN; busy=1 from E0.
- RUN: one iteration per cycle, counter decrements.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - At counter=1 the next edge goes to FIX.
- FIX: one cycle.
  - Applies two's-complement sign correction. MULT: product negated if signs differ. DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Writes hi/lo at edge E0+WIDTH+1, returns to IDLE, sets busy=0, done=1 for exactly one cycle.
  - Total latency: WIDTH+1 cycles from accept to result.
- Result mapping:
  - MULT/MULTU: hi=upper WIDTH bits, lo=lower WIDTH bits.
  - DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero:
  - No iteration anomaly; still takes the full latency.
  - Result hi=srca, lo=all ones; div0=1.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives lo=-2^(WIDTH-1), hi=0, div0=0.
- start while busy: ignored (no queueing). The bench must see no change to the in-flight result.
- flush while busy: next edge returns to IDLE, busy=0, hi/lo unchanged, no done pulse.
- flush and start in the same cycle in IDLE: flush wins; the start is dropped.
- hlwrite in IDLE: writes the selected register at the next edge.
- hlwrite while busy: ignored; the engine owns HI/LO until done.
- hlwrite coincident with the FIX write edge: FIX result wins.
- stall: a read requested during the done cycle is not stalled and sees the new hi/lo.
- Operand registers are captured at accept; srca/srcb changes afterwards have no effect.

Test Plan:
- Reset, then MULT srca=0xFFFFFFFD (-3), srcb=7 -> busy 33 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE. Same operands with MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, div0=1. Next start (MULTU 1x1) clears div0.
- mfhl_req held from accept -> stall=1 for exactly 33 cycles, 0 in the done cycle. hlwrite (hlsel=0, 0xABCD) mid-operation is ignored; the same write in IDLE gives lo=0xABCD next cycle.
- flush at cycle 10 of a DIV -> busy=0 next edge, hi/lo keep prior values, no done pulse.
- reset=0 at cycle 20 of a MULT -> all outputs 0 immediately, without waiting for a clock edge.
- start pulsed mid-operation -> original result unaffected.
